// File: rtl/skew_feeder.sv
// skew_feeder
// -----------------------------------------------------------------------------
// Purpose: accepts one 4x4 matrix of DW-bit elements per valid/ready handshake
// and replays it as a diagonally skewed 4-lane stream over 7 consecutive
// cycles. Step t drives lane l with element (row l, col t-l) whenever
// 0 <= t-l <= 3. Otherwise the lane is zero. The per-lane valid wavefront is
// 0001, 0011, 0111, 1111, 1110, 1100, 1000.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; it aborts any wavefront in flight
//   mat_in     16*DW matrix, element (r,c) at bits [DW*(4r+c) +: DW]
//   mat_valid  mat_in is valid
//   mat_ready  a matrix can be accepted this cycle (combinational)
//   skout      4*DW skewed stream, lane l at bits [DW*l +: DW] (registered)
//   dv_skout   per-lane valid, bit l qualifies lane l (registered)
//   busy       a matrix is being emitted (registered)
//   done       one-cycle pulse during the last step, dv_skout=1000 (registered)
//
// Build option: define SKEW_B2B_EN to also accept a matrix during the step-6
// cycle. The next wavefront then follows with no bubble.
// -----------------------------------------------------------------------------
module skew_feeder #(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [16*DW-1:0] mat_in,
    input  logic             mat_valid,
    output logic             mat_ready,
    output logic [4*DW-1:0]  skout,
    output logic [3:0]       dv_skout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        step_reg, step_next;
    logic [16*DW-1:0]  hold_reg, hold_next;
    logic [4*DW-1:0]   skout_reg, skout_next;
    logic [3:0]        dv_reg, dv_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              xfer;

`ifdef SKEW_B2B_EN
    // The last step can overlap with the next handshake.
    assign mat_ready = !rst && ((state_reg == IDLE) ||
                                ((state_reg == SEND) && (step_reg == 3'd6)));
`else
    assign mat_ready = !rst && (state_reg == IDLE);
`endif

    assign xfer = mat_valid && mat_ready;

    // Next-state logic. step_next is the step shown in the cycle after this edge.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        hold_next  = hold_reg;
        if (xfer) begin
            state_next = SEND;
            step_next  = 3'd0;
            hold_next  = mat_in;
        end else if (state_reg == SEND) begin
            if (step_reg == 3'd6) begin
                state_next = IDLE;
                step_next  = 3'd0;
            end else begin
                step_next = step_reg + 3'd1;
            end
        end
    end

    // Per-lane output selection. The outputs are registered, so the lanes are
    // computed from the next step and the next holding value. This lets
    // step 0 appear in the cycle right after the handshake.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [2:0] col;
            logic       lane_on;
            assign col     = step_next - 3'(gi);
            assign lane_on = (state_next == SEND) && (step_next >= 3'(gi)) &&
                             (col <= 3'd3);
            assign dv_next[gi] = lane_on;
            // Inactive lanes are forced to zero so stale data never leaks out.
            assign skout_next[DW*gi +: DW] =
                lane_on ? hold_next[DW*4*gi + DW*col[1:0] +: DW] : '0;
        end
    endgenerate

    assign busy_next = (state_next == SEND);
    assign done_next = (state_next == SEND) && (step_next == 3'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            skout_reg <= '0;
            dv_reg    <= 4'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            skout_reg <= skout_next;
            dv_reg    <= dv_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // The holding register is pure data. It only moves on a transfer.
    always_ff @(posedge clk) begin
        hold_reg <= hold_next;
    end

    assign skout    = skout_reg;
    assign dv_skout = dv_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder
// Scoreboard bench for skew_feeder. On every accepted handshake, seven
// expected steps are pushed to a queue. A negedge monitor pops and compares
// them against the stream. The scenario tasks add their own inline checks
// for timing, bubbles and reset behaviour.
`timescale 1ns/1ps
module tb_skew_feeder;
    localparam int DW = 8;
`ifdef SKEW_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    localparam logic [127:0] MAT_A = 128'h44434241_34333231_24232221_14131211;
    localparam logic [127:0] MAT_B = 128'h8899aabb_ccddeeff_01234567_89abcdef;
    localparam logic [31:0] BASIC_SK [7] = '{32'h00000011, 32'h00002112, 32'h00312213,
        32'h41322314, 32'h42332400, 32'h43340000, 32'h44000000};
    localparam logic [3:0] BASIC_DV [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
        4'b1110, 4'b1100, 4'b1000};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] mat_in = '0;
    logic         mat_valid = 1'b0;
    logic         mat_ready;
    logic [31:0]  skout;
    logic [3:0]   dv_skout;
    logic         busy, done;

    always #5 clk = ~clk;

    skew_feeder #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .mat_in(mat_in), .mat_valid(mat_valid),
        .mat_ready(mat_ready), .skout(skout), .dv_skout(dv_skout),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [31:0] sk;
        logic [3:0]  dv;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic logic [31:0] model_sk(input logic [127:0] m, input int t);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < 4; l++)
            if (t - l >= 0 && t - l <= 3) r[8*l +: 8] = m[8*(4*l + t - l) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] model_dv(input int t);
        logic [3:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) r[l] = (t - l >= 0 && t - l <= 3);
        return r;
    endfunction

    // Scoreboard monitor: compare first, then push if a transfer is about to happen.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) sb.delete();
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++; if (skout !== mon_e.sk) begin errors++; $display("FAIL sb_skout got %h want %h", skout, mon_e.sk); end
                checks++; if (dv_skout !== mon_e.dv) begin errors++; $display("FAIL sb_dv got %b want %b", dv_skout, mon_e.dv); end
                checks++; if (done !== mon_e.dn) begin errors++; $display("FAIL sb_done got %b want %b", done, mon_e.dn); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy got %b want 1", busy); end
            end else begin
                checks++; if (dv_skout !== 4'd0 || skout !== 32'd0) begin errors++; $display("FAIL sb_idle got dv=%b sk=%h want 0", dv_skout, skout); end
                checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sb_idle_flags got done=%b busy=%b want 0", done, busy); end
            end
            if (!rst && mat_valid && mat_ready)
                for (int t = 0; t < 7; t++) sb.push_back(exp_t'({model_sk(mat_in, t), model_dv(t), t == 6}));
        end
    end

    // Present one matrix for one cycle. Returns one time unit after the handshake edge.
    task automatic send(input logic [127:0] m);
        @(posedge clk); #1;
        mat_in = m; mat_valid = 1'b1;
        @(posedge clk); #1;
        mat_valid = 1'b0;
        mat_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset;
        rst = 1'b1; mat_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (skout !== 32'd0 || dv_skout !== 4'd0) begin errors++; $display("FAIL reset_out got sk=%h dv=%b want 0", skout, dv_skout); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0", busy, done); end
        checks++; if (mat_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", mat_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mat_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", mat_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        logic exp_d, exp_r;
        send(MAT_A);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            exp_d = (t == 6);
            exp_r = B2B && (t == 6);
            checks++; if (skout !== BASIC_SK[t]) begin errors++; $display("FAIL basic_skout step %0d got %h want %h", t, skout, BASIC_SK[t]); end
            checks++; if (dv_skout !== BASIC_DV[t]) begin errors++; $display("FAIL basic_dv step %0d got %b want %b", t, dv_skout, BASIC_DV[t]); end
            checks++; if (done !== exp_d) begin errors++; $display("FAIL basic_done step %0d got %b want %b", t, done, exp_d); end
            checks++; if (mat_ready !== exp_r) begin errors++; $display("FAIL basic_ready step %0d got %b want %b", t, mat_ready, exp_r); end
        end
        @(negedge clk);
        checks++; if (dv_skout !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end got dv=%b busy=%b want 0", dv_skout, busy); end
    endtask

    task automatic test_zeroing;
        send({128{1'b1}});
        @(negedge clk);
        checks++; if (skout !== 32'h000000ff) begin errors++; $display("FAIL zero_step0 got %h want 000000ff", skout); end
        repeat (5) @(negedge clk);
        checks++; if (skout !== 32'hffff0000) begin errors++; $display("FAIL zero_step5 got %h want ffff0000", skout); end
        repeat (2) @(negedge clk);
    endtask

    // Feed two matrices with mat_valid held high. Return the dv history,
    // the transfer count, and the done-pulse positions.
    task automatic run_pair(input logic [127:0] m0, input logic [127:0] m1,
                            output logic [3:0] dvh [24], output int n_xfer,
                            output int d0, output int d1, output int early_xfer);
        logic xf;
        n_xfer = 0; d0 = -1; d1 = -1; early_xfer = -1;
        @(posedge clk); #1 mat_in = m0; mat_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            dvh[k] = dv_skout;
            if (done === 1'b1) begin if (d0 < 0) d0 = k; else if (d1 < 0) d1 = k; end
            xf = mat_valid && mat_ready;
            if (xf) n_xfer++;
            if (k == 6) early_xfer = n_xfer;
            @(posedge clk); #1;
            if (xf && n_xfer == 1) mat_in = m1;
            if (xf && n_xfer == 2) mat_valid = 1'b0;
        end
    endtask

    task automatic test_held;
        logic [3:0] dvh [24];
        int n_xfer, d0, d1, early, end_idx, next_idx, gap, exp_gap;
        run_pair(MAT_A, MAT_B, dvh, n_xfer, d0, d1, early);
        end_idx = -1; next_idx = -1;
        for (int k = 0; k < 24; k++) begin
            if (end_idx < 0 && dvh[k] == 4'b1000) end_idx = k;
            else if (end_idx >= 0 && next_idx < 0 && dvh[k] != 4'd0) next_idx = k;
        end
        gap = (end_idx < 0 || next_idx < 0) ? -1 : next_idx - end_idx - 1;
        exp_gap = B2B ? 0 : 1;
        checks++; if (early !== 1) begin errors++; $display("FAIL held_no_early_xfer got %0d want 1", early); end
        checks++; if (n_xfer !== 2) begin errors++; $display("FAIL held_xfers got %0d want 2", n_xfer); end
        checks++; if (gap !== exp_gap) begin errors++; $display("FAIL held_gap got %0d want %0d", gap, exp_gap); end
    endtask

    task automatic test_reset_mid;
        bit found;
        send(MAT_B);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dv_skout === 4'b1111) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_find_step3 got none want dv=1111"); end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (skout !== 32'd0 || dv_skout !== 4'd0) begin errors++; $display("FAIL mid_out got sk=%h dv=%b want 0", skout, dv_skout); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || mat_ready !== 1'b0) begin errors++; $display("FAIL mid_flags got busy=%b done=%b rdy=%b want 0", busy, done, mat_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mat_ready !== 1'b1 || dv_skout !== 4'd0) begin errors++; $display("FAIL mid_release got rdy=%b dv=%b want 1/0", mat_ready, dv_skout); end
        send(MAT_A);
        @(negedge clk);
        checks++; if (dv_skout !== 4'b0001) begin errors++; $display("FAIL mid_restart got %b want 0001", dv_skout); end
        repeat (7) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [3:0] dvh [24];
        int n_xfer, d0, d1, early, run, best, exp_run, exp_sp;
        run_pair(MAT_B, MAT_A, dvh, n_xfer, d0, d1, early);
        run = 0; best = 0;
        for (int k = 0; k < 24; k++) begin
            run = (dvh[k] != 4'd0) ? run + 1 : 0;
            if (run > best) best = run;
        end
        exp_run = B2B ? 14 : 7;
        exp_sp  = B2B ? 7 : 8;
        checks++; if (best !== exp_run) begin errors++; $display("FAIL b2b_valid_run got %0d want %0d", best, exp_run); end
        checks++; if (d0 < 0 || d1 - d0 !== exp_sp) begin errors++; $display("FAIL b2b_done_spacing got %0d want %0d", d1 - d0, exp_sp); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zeroing;
        test_held;
        test_reset_mid;
        test_back_to_back;
        repeat (3) @(negedge clk);
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Transmit-side counterpart of the activation/collect stage.
- Accepts one 4x4 byte matrix per handshake and replays it as a diagonally skewed 32-bit stream over 7 cycles.
- Drives the 4-bit wavefront valid pattern 0001, 0011, 0111, 1111, 1110, 1100, 1000, which the activation/collect stage decodes.
- Sits between the matrix buffer and the systolic-array/activation datapath.

Parameters:
- DW, 8: element width in bits. Matrix port is 16*DW; stream port is 4*DW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- mat_in  input  16*DW  matrix. Element (r,c) is at bits [DW*(4r+c) +: DW], r,c in 0..3.
- mat_valid  input  1  mat_in is valid.
- mat_ready  output  1  block can accept a matrix this cycle.
- skout  output  4*DW  skewed stream. Lane l is at bits [DW*l +: DW].
- dv_skout  output  4  per-lane valid. Bit l qualifies lane l.
- busy  output  1  a matrix is being emitted.
- done  output  1  one-cycle pulse coincident with the last step (dv_skout=1000).

Behaviour:
- Reset, sampled at posedge:
  - skout=0, dv_skout=0, busy=0, done=0, step=0, state=IDLE.
  - mat_ready=0 while rst is high.
  - Reset mid-operation aborts immediately. The partial wavefront is dropped and never resumed.
  - First cycle after rst deasserts: mat_ready=1.
- States:
  - IDLE: mat_ready=1, busy=0.
  - SEND: busy=1, 3-bit step counter 0..6.
- Handshake:
  - A transfer occurs at a posedge where mat_valid=1 and mat_ready=1. mat_in is latched into a 16*DW holding register.
  - mat_in is ignored when no transfer occurs.
  - mat_valid may drop without a transfer; no state change results.
- Latency:
  - All outputs except mat_ready are registered.
  - Step 0 appears in the cycle after the handshake edge.
  - Steps 0..6 appear in 7 consecutive cycles. There is no stall.
- Step t, lane l:
  - dv_skout[l] = 1 iff 0 <= t-l <= 3.
  - If valid, skout lane l = element (row l, col t-l). Otherwise the lane is driven 0, never stale data.
  - Resulting dv_skout sequence: t0=0001, t1=0011, t2=0111, t3=1111, t4=1110, t5=1100, t6=1000.
- After step 6:
  - At the next edge, outputs clear (dv_skout=0, skout=0), step=0, state=IDLE, unless the optional feature below accepts a new matrix.
- done:
  - 1 exactly during the step-6 cycle; 0 otherwise.
- Timing without the feature:
  - mat_ready=0 throughout SEND, including step 6.
  - Minimum matrix-to-matrix period is 8 cycles (one bubble cycle with dv_skout=0 between wavefronts).
- The holding register changes only on a transfer. Emitted data is immune to mat_in changes during SEND.
- Step counter never exceeds 6. There is no wrap-around within a matrix.

Optional Feature:
- Macro: SKEW_B2B_EN.
- Defined:
  - mat_ready=1 also during the step-6 cycle.
  - A transfer at the end of step 6 loads the new matrix. The next cycle emits its step 0 (dv_skout=0001) with no bubble.
  - Back-to-back period is 7 cycles; busy stays 1 across the boundary.
  - done still pulses once per matrix.
- Undefined: mat_ready = (state==IDLE) && !rst only; behaviour as above.

Test Plan:
- Basic wavefront.
  - Stimulus: rst, then mat_in=128'h44434241_34333231_24232221_14131211 with mat_valid=1 for one cycle.
  - Required: steps 0..6 give skout=00000011, 00002112, 00312213, 41322314, 42332400, 43340000, 44000000; dv_skout as listed; done=1 only on step 6; mat_ready=0 during SEND.
- Invalid-lane zeroing.
  - Stimulus: all-0xFF matrix.
  - Required: step 0 skout=000000FF; step 5 skout=FFFF0000; no 0xFF appears on any lane whose dv bit is 0.
- Input held busy.
  - Stimulus: mat_valid held 1 with a new mat_in after the first transfer.
  - Required: no second transfer until mat_ready=1. Emitted data equals the first matrix. Without SKEW_B2B_EN, exactly one dv_skout=0 cycle separates the wavefronts.
- Reset mid-operation.
  - Stimulus: assert rst during step 3.
  - Required: next cycle skout=0, dv_skout=0, busy=0, done=0, mat_ready=0. After release, mat_ready=1 and a new matrix starts at step 0.
- Back-to-back (SKEW_B2B_EN defined).
  - Stimulus: two matrices presented continuously.
  - Required: dv_skout=1000 is immediately followed by 0001; 14 consecutive valid cycles; two done pulses 7 cycles apart.
